led_pattern_seq: RTL

Parametrised multi-channel LED sequencer driven by an external timebase tick. Each channel runs in one of four modes (off, on, pattern, gated toggle) over a programmable frame of FRAME_LEN ticks. Configuration is double-buffered so that changes land cleanly on frame boundaries. It sits downstream of the tick generator and replaces the fixed two-LED toggle/pattern block.

---
 rtl/led_pattern_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/led_pattern_seq.sv
// Multi-channel LED sequencer advanced by an external timebase tick.
// Each channel is OFF, ON, PATTERN or TOGGLE over a frame of FRAME_LEN ticks.
// Build option LED_SEQ_SHADOW_EN: when defined, config writes go to per-channel
// shadow registers and are committed on frame wrap or while the sequencer is
// frozen (enable=0); when undefined, writes land directly in the active config.
module led_pattern_seq #(
  parameter int unsigned NUM_LEDS  = 2,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned PW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  parameter int unsigned FW        = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 enable_i,
  input  logic                 cfg_we_i,
  input  logic [PW-1:0]        cfg_led_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic [FRAME_LEN-1:0] cfg_pattern_i,
  output logic [NUM_LEDS-1:0]  led_o,
  output logic [FW-1:0]        frame_pos_o,
  output logic                 frame_wrap_o,
  output logic                 cfg_pending_o,
  output logic                 cfg_err_o
);

  typedef enum logic [1:0] {ModeOff, ModeOn, ModePattern, ModeToggle} mode_e;

  logic [FW-1:0]        pos_q, pos_d, pos_next;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic                 advance, wr_valid;
  logic [NUM_LEDS-1:0]  wr_hit;

  mode_e                act_mode_q [NUM_LEDS];
  mode_e                act_mode_d [NUM_LEDS];
  logic [FRAME_LEN-1:0] act_pat_q  [NUM_LEDS];
  logic [FRAME_LEN-1:0] act_pat_d  [NUM_LEDS];

  // Frame position, write decode and one-cycle status pulses
  always_comb begin
    advance  = tick_i & enable_i;
    pos_next = (pos_q == FW'(FRAME_LEN - 1)) ? '0 : pos_q + 1'b1;
    pos_d    = advance ? pos_next : pos_q;
    wrap_d   = advance && (pos_next == '0);
    wr_valid = cfg_we_i && (32'(cfg_led_i) < NUM_LEDS);
    err_d    = cfg_we_i && !wr_valid;
    for (int i = 0; i < NUM_LEDS; i++) begin
      wr_hit[i] = wr_valid && (32'(cfg_led_i) == i);
    end
  end

`ifdef LED_SEQ_SHADOW_EN
  mode_e                shd_mode_q [NUM_LEDS];
  mode_e                shd_mode_d [NUM_LEDS];
  logic [FRAME_LEN-1:0] shd_pat_q  [NUM_LEDS];
  logic [FRAME_LEN-1:0] shd_pat_d  [NUM_LEDS];
  logic [NUM_LEDS-1:0]  dirty_q, dirty_d;
  logic                 commit;

  // Commit uses pre-edge shadows; a coincident write refills the shadow and stays dirty
  always_comb begin
    commit = (advance && (pos_next == '0)) || !enable_i;
    for (int i = 0; i < NUM_LEDS; i++) begin
      act_mode_d[i] = (commit && dirty_q[i]) ? shd_mode_q[i] : act_mode_q[i];
      act_pat_d[i]  = (commit && dirty_q[i]) ? shd_pat_q[i]  : act_pat_q[i];
      shd_mode_d[i] = wr_hit[i] ? mode_e'(cfg_mode_i) : shd_mode_q[i];
      shd_pat_d[i]  = wr_hit[i] ? cfg_pattern_i       : shd_pat_q[i];
      dirty_d[i]    = (dirty_q[i] && !commit) || wr_hit[i];
    end
  end

  // Shadow config and dirty flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      dirty_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shd_mode_q[i] <= ModeOff;
        shd_pat_q[i]  <= '0;
      end
    end else begin
      dirty_q <= dirty_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shd_mode_q[i] <= shd_mode_d[i];
        shd_pat_q[i]  <= shd_pat_d[i];
      end
    end
  end

  assign cfg_pending_o = |dirty_q;
`else
  // Direct writes: the new config is already visible to this edge's LED update
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      act_mode_d[i] = wr_hit[i] ? mode_e'(cfg_mode_i) : act_mode_q[i];
      act_pat_d[i]  = wr_hit[i] ? cfg_pattern_i       : act_pat_q[i];
    end
  end

  assign cfg_pending_o = 1'b0;
`endif

  // Per-channel LED evaluation at the upcoming frame position
  always_comb begin
    led_d = led_q;
    if (advance) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        unique case (act_mode_d[i])
          ModeOff:     led_d[i] = 1'b0;
          ModeOn:      led_d[i] = 1'b1;
          ModePattern: led_d[i] = act_pat_d[i][pos_next];
          ModeToggle:  led_d[i] = led_q[i] ^ act_pat_d[i][pos_next];
          default:     led_d[i] = led_q[i];
        endcase
      end
    end
  end

  // Active config, position and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q  <= '0;
      led_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        act_mode_q[i] <= ModeOff;
        act_pat_q[i]  <= '0;
      end
    end else begin
      pos_q  <= pos_d;
      led_q  <= led_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        act_mode_q[i] <= act_mode_d[i];
        act_pat_q[i]  <= act_pat_d[i];
      end
    end
  end

  assign led_o        = led_q;
  assign frame_pos_o  = pos_q;
  assign frame_wrap_o = wrap_q;
  assign cfg_err_o    = err_q;

endmodule
